mor1kx_dpram_fifo_ctrl: RTL and testbench



---
 rtl/mor1kx_dpram_fifo_ctrl.sv | 95 +++++++++
 tb/tb_mor1kx_dpram_fifo_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// First-word-fall-through FIFO sequencer around a simple dual-port RAM with 1-cycle registered read.
// Optional macro MOR1KX_DPRAM_FIFO_CTRL_BYPASS_EN: push-into-empty reads the written address in the same cycle.
module mor1kx_dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH+1:0] count_o,
  output logic                  overflow_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  output logic                  ram_re_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0]         wptr_reg, rptr_reg;
  logic [PW-1:0]         ram_cnt;
  logic                  valid_reg, overflow_reg;
  logic [ADDR_WIDTH+1:0] count_reg, count_next;
  logic                  acc_push, acc_pop, re;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign ram_cnt  = wptr_reg - rptr_reg;
  assign full_o   = (ram_cnt == RAM_DEPTH);
  assign acc_push = push_i & ~full_o & ~flush_i;
  assign acc_pop  = pop_i & valid_reg & ~flush_i;

`ifdef MOR1KX_DPRAM_FIFO_CTRL_BYPASS_EN
  // Empty FIFO: read the slot being written; the RAM forwards the write data.
  assign re = (((ram_cnt != '0) & (~valid_reg | acc_pop)) |
               ((ram_cnt == '0) & acc_push & ~valid_reg)) & ~flush_i;
`else
  assign re = (ram_cnt != '0) & (~valid_reg | acc_pop) & ~flush_i;
`endif

  assign ram_we_o    = acc_push;
  assign ram_waddr_o = wptr_reg[ADDR_WIDTH-1:0];
  assign ram_din_o   = data_i;
  assign ram_re_o    = re;
  assign ram_raddr_o = rptr_reg[ADDR_WIDTH-1:0];

  assign data_o     = ram_dout_i;
  assign valid_o    = valid_reg;
  assign count_o    = count_reg;
  assign overflow_o = overflow_reg;

  always_comb begin
    count_next = count_reg;
    if (acc_push && !acc_pop)
      count_next = count_reg + 1'b1;
    else if (acc_pop && !acc_push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      valid_reg    <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush_i) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      valid_reg    <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (acc_push)
        wptr_reg <= wptr_reg + 1'b1;
      if (re)
        rptr_reg <= rptr_reg + 1'b1;
      if (re)
        valid_reg <= 1'b1;
      else if (acc_pop)
        valid_reg <= 1'b0;
      count_reg    <= count_next;
      overflow_reg <= push_i & full_o;
    end
  end

endmodule

// File: tb/tb_mor1kx_dpram_fifo_ctrl.sv
// Bench for mor1kx_dpram_fifo_ctrl: directed cases plus random traffic against a queue-based model.
module tb_mor1kx_dpram_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
`ifdef MOR1KX_DPRAM_FIFO_CTRL_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          valid_o, full_o, overflow_o;
  logic [AW+1:0] count_o;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_din, ram_dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mor1kx_dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .push_i(push_i), .data_i(data_i),
    .pop_i(pop_i), .data_o(data_o), .valid_o(valid_o), .full_o(full_o),
    .count_o(count_o), .overflow_o(overflow_o), .ram_waddr_o(ram_waddr),
    .ram_we_o(ram_we), .ram_din_o(ram_din), .ram_raddr_o(ram_raddr),
    .ram_re_o(ram_re), .ram_dout_i(ram_dout)
  );

  // Simple dual-port RAM with registered read.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    if (ram_re) begin
`ifdef MOR1KX_DPRAM_FIFO_CTRL_BYPASS_EN
      if (ram_we && ram_waddr == ram_raddr) ram_dout <= ram_din;
      else
`endif
      ram_dout <= mem[ram_raddr];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: queue of accepted entries, each with the first cycle it may be seen at the head.
  typedef struct {
    logic [DW-1:0] d;
    int            ready;
  } ent_t;
  ent_t q[$];
  int   cyc = 0;
  bit   ovf_m = 0;

  initial begin
    bit vexp, fexp, wexp, was_empty;
    forever begin
      @(negedge clk); #3;
      if (rst) begin q.delete(); ovf_m = 0; end
      vexp = (q.size() > 0) && (q[0].ready <= cyc);
      fexp = ((q.size() - int'(vexp)) == DEPTH);
      wexp = push_i && !fexp && !flush_i && !rst;
      chk("m_valid", {31'b0, valid_o}, {31'b0, vexp});
      chk("m_count", {28'b0, count_o}, q.size());
      chk("m_full", {31'b0, full_o}, {31'b0, fexp});
      chk("m_ovf", {31'b0, overflow_o}, {31'b0, ovf_m});
      if (!rst) chk("m_we", {31'b0, ram_we}, {31'b0, wexp});
      if (vexp) chk("m_data", data_o, q[0].d);
      if (wexp) chk("m_din", ram_din, data_i);
      @(posedge clk);
      if (rst || flush_i) begin
        q.delete();
        ovf_m = 0;
      end else begin
        was_empty = (q.size() == 0);
        ovf_m = push_i && fexp;
        if (pop_i && vexp) void'(q.pop_front());
        if (push_i && !fexp)
          q.push_back('{d: data_i, ready: (LAT == 1 && was_empty) ? cyc + 1 : cyc + 2});
      end
      cyc++;
    end
  end

  task automatic step(input bit p, input logic [DW-1:0] d, input bit po, input bit fl);
    @(negedge clk); #1;
    rst = 1'b0; push_i = p; data_i = d; pop_i = po; flush_i = fl;
    #1;
  endtask

  task automatic idle();
    step(0, '0, 0, 0);
  endtask

  initial begin
    bit p, po, fl;
    int pp, pq;
    repeat (2) @(negedge clk);

    // Push into empty FIFO
    step(1, 32'hA1, 0, 0);
    chk("t1_count0", {28'b0, count_o}, 0);
    chk("t1_valid0", {31'b0, valid_o}, 0);
    idle();
    chk("t1_count1", {28'b0, count_o}, 1);
    chk("t1_valid_c1", {31'b0, valid_o}, (LAT == 1) ? 1 : 0);
    idle();
    chk("t1_valid_c2", {31'b0, valid_o}, 1);
    chk("t1_data", data_o, 32'hA1);
    step(0, '0, 1, 0);
    idle();
    chk("t1_empty", {31'b0, valid_o}, 0);

    // Fill to capacity, overflow, drain back-to-back
    for (int i = 1; i <= 5; i++) step(1, i, 0, 0);
    step(1, 32'h06, 0, 0);
    chk("t2_count5", {28'b0, count_o}, 5);
    chk("t2_full", {31'b0, full_o}, 1);
    idle();
    chk("t2_ovf", {31'b0, overflow_o}, 1);
    idle();
    chk("t2_ovf_clr", {31'b0, overflow_o}, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, '0, 1, 0);
      chk("t2_pop_valid", {31'b0, valid_o}, 1);
      chk("t2_pop_data", data_o, i);
    end
    idle();
    chk("t2_valid_end", {31'b0, valid_o}, 0);
    chk("t2_count_end", {28'b0, count_o}, 0);

    // Push while full with pop in same cycle
    for (int i = 1; i <= 5; i++) step(1, i, 0, 0);
    idle();
    step(1, 32'h77, 1, 0);
    chk("t3_head01", data_o, 32'h01);
    idle();
    chk("t3_ovf", {31'b0, overflow_o}, 1);
    chk("t3_count4", {28'b0, count_o}, 4);
    chk("t3_head02", data_o, 32'h02);
    step(0, '0, 0, 1);
    idle();
    chk("t3_flushed", {28'b0, count_o}, 0);

    // Steady streaming with pointer wrap
    step(1, 32'h10, 0, 0);
    step(1, 32'h11, 0, 0);
    idle();
    idle();
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h12 + i, 1, 0);
      chk("t4_data", data_o, 32'h10 + i);
      chk("t4_count", {28'b0, count_o}, 2);
      chk("t4_full", {31'b0, full_o}, 0);
    end
    step(0, '0, 0, 1);

    // Flush overrides push
    for (int i = 0; i < 3; i++) step(1, 32'h31 + i, 0, 0);
    idle();
    idle();
    step(1, 32'h99, 0, 1);
    chk("t5_no_we", {31'b0, ram_we}, 0);
    idle();
    chk("t5_valid0", {31'b0, valid_o}, 0);
    chk("t5_count0", {28'b0, count_o}, 0);
    step(1, 32'h5A, 0, 0);
    repeat (LAT) idle();
    chk("t5_head_valid", {31'b0, valid_o}, 1);
    chk("t5_head", data_o, 32'h5A);
    step(0, '0, 0, 1);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1, 32'h41 + i, 0, 0);
    idle();
    chk("t6_pre_count", {28'b0, count_o}, 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", {31'b0, valid_o}, 0);
    chk("t6_full", {31'b0, full_o}, 0);
    chk("t6_count", {28'b0, count_o}, 0);
    chk("t6_ovf", {31'b0, overflow_o}, 0);
    step(1, 32'hC3, 0, 0);
    repeat (LAT) idle();
    chk("t6_head_valid", {31'b0, valid_o}, 1);
    chk("t6_head", data_o, 32'hC3);

    // Random traffic with varying push/pop bias
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) begin
        pp = $urandom_range(10, 90);
        pq = $urandom_range(10, 90);
      end
      p  = ($urandom_range(0, 99) < pp);
      po = ($urandom_range(0, 99) < pq);
      fl = ($urandom_range(0, 63) == 0);
      step(p, $urandom, po, fl);
    end
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
